// File: rtl/four_bit_sar_search_if.sv
// Bus between the SAR search engine and the external 4-bit magnitude comparator.
// master = search engine side, slave = comparator/requester side.
interface four_bit_sar_search_if;
    // start is a level request honoured only while idle; done is a one-cycle
    // pulse qualifying result, and result/err hold until the next accepted start.
    logic       start;
    logic       eq_in;
    logic       gr_in;
    logic       lt_in;
    logic [3:0] probe;
    logic       busy;
    logic       done;
    logic [3:0] result;
    logic       err;
    logic [1:0] dbg_state;

    modport master (
        input  start, eq_in, gr_in, lt_in,
        output probe, busy, done, result, err, dbg_state
    );

    modport slave (
        output start, eq_in, gr_in, lt_in,
        input  probe, busy, done, result, err, dbg_state
    );
endinterface

// File: rtl/four_bit_sar_search.sv
// Successive-approximation search for an unknown 4-bit target, MSB first.
// Optional macro SAR_EARLY_EXIT_EN: finish as soon as the comparator reports equality.
module four_bit_sar_search (
    input  logic                         clk,
    input  logic                         rst,
    four_bit_sar_search_if.master        bus
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SEARCH = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    logic [1:0] state_q, state_d;
    logic [3:0] probe_q, probe_d;
    logic [3:0] result_q, result_d;
    logic [1:0] idx_q, idx_d;
    logic       err_q, err_d;

    logic       flags_one_hot;
    logic       keep_bit;
    logic [3:0] cur_bit;
    logic [3:0] next_bit;
    logic [3:0] trial;

    assign flags_one_hot = ({bus.eq_in, bus.gr_in, bus.lt_in} == 3'b100) ||
                           ({bus.eq_in, bus.gr_in, bus.lt_in} == 3'b010) ||
                           ({bus.eq_in, bus.gr_in, bus.lt_in} == 3'b001);

    // Equality keeps the trial bit: target >= probe means the bit belongs in the answer.
    assign keep_bit = bus.gr_in | bus.eq_in;
    assign cur_bit  = 4'b0001 << idx_q;
    assign next_bit = 4'b0001 << (idx_q - 2'd1);
    assign trial    = keep_bit ? probe_q : (probe_q & ~cur_bit);

    always_comb begin
        state_d  = state_q;
        probe_d  = probe_q;
        result_d = result_q;
        idx_d    = idx_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d  = S_SEARCH;
                    probe_d  = 4'b1000;
                    idx_d    = 2'd3;
                    err_d    = 1'b0;
                    result_d = 4'b0000;
                end
            end
            S_SEARCH: begin
                if (!flags_one_hot) begin
                    err_d    = 1'b1;
                    result_d = 4'b0000;
                    probe_d  = 4'b0000;
                    idx_d    = 2'd3;
                    state_d  = S_IDLE;
                end
`ifdef SAR_EARLY_EXIT_EN
                else if (bus.eq_in) begin
                    result_d = probe_q;
                    probe_d  = 4'b0000;
                    idx_d    = 2'd3;
                    state_d  = S_DONE;
                end
`endif
                else if (idx_q == 2'd0) begin
                    result_d = trial;
                    probe_d  = 4'b0000;
                    idx_d    = 2'd3;
                    state_d  = S_DONE;
                end else begin
                    probe_d = trial | next_bit;
                    idx_d   = idx_q - 2'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                probe_d = 4'b0000;
                idx_d   = 2'd3;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            probe_q  <= 4'b0000;
            result_q <= 4'b0000;
            idx_q    <= 2'd3;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            probe_q  <= probe_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            err_q    <= err_d;
        end
    end

    assign bus.probe     = probe_q;
    assign bus.busy      = (state_q == S_SEARCH);
    assign bus.done      = (state_q == S_DONE);
    assign bus.result    = result_q;
    assign bus.err       = err_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_four_bit_sar_search.sv
// Bench for four_bit_sar_search: comparator model with a settable target and a
// fault override; expected probe sequences come from a plain SAR model.
module tb_four_bit_sar_search;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] target;
  logic bad;

  four_bit_sar_search_if bus();

  four_bit_sar_search dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Comparator: target is operand A, probe is operand B; bad forces gr and lt together.
  assign bus.eq_in = bad ? 1'b0 : (target == bus.probe);
  assign bus.gr_in = bad ? 1'b1 : (target > bus.probe);
  assign bus.lt_in = bad ? 1'b1 : (target < bus.probe);

  int checks = 0;
  int failures = 0;
  logic [3:0] exp_q[$];
  int exp_lat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Binary search over 0..15: try each power of two from the top, keep it when
  // the target is at least the trial value.
  task automatic build_model(input logic [3:0] t);
    int v;
    int p;
    v = 0;
    exp_q.delete();
    exp_lat = 0;
    for (int i = 3; i >= 0; i--) begin
      p = v + (1 << i);
      exp_q.push_back(p[3:0]);
      exp_lat++;
`ifdef SAR_EARLY_EXIT_EN
      if (p == int'(t)) break;
`endif
      if (int'(t) >= p) v = p;
    end
    exp_lat++;
  endtask

  task automatic run_search(input logic [3:0] t, input bit poke_start);
    int cyc;
    bit seen;
    build_model(t);
    @(negedge clk);
    target = t;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    seen = 1'b0;
    while (!seen && cyc <= 8) begin
      if (cyc == 1) check("err_cleared_on_start", bus.err, 0);
      if (bus.done) begin
        seen = 1'b1;
        check("latency", cyc, exp_lat);
        check("result", bus.result, t);
        check("done_probe_zero", bus.probe, 0);
        check("done_busy_low", bus.busy, 0);
        check("done_err_low", bus.err, 0);
        check("probes_all_used", exp_q.size(), 0);
        bus.start = poke_start;
      end else begin
        check("busy_in_search", bus.busy, 1);
        check("probe_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("probe_value", bus.probe, exp_q.pop_front());
        bus.start = poke_start && (cyc == 2);
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    check("done_seen", seen, 1);
    check("idle_done_low", bus.done, 0);
    check("idle_busy_low", bus.busy, 0);
    check("idle_probe_zero", bus.probe, 0);
    check("result_held", bus.result, t);
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    target = 4'd0;
    bad = 1'b0;
    @(negedge clk);
    check("rst_probe", bus.probe, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_result", bus.result, 0);
    check("rst_err", bus.err, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_search(4'd9, 1'b0);
    run_search(4'd8, 1'b0);
    run_search(4'd0, 1'b0);
    run_search(4'd15, 1'b0);
    run_search(4'd5, 1'b1);

    // Comparator fault on the second compare.
    @(negedge clk);
    target = 4'd9;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bad = 1'b1;
    @(negedge clk);
    bad = 1'b0;
    check("fault_err_set", bus.err, 1);
    check("fault_busy_low", bus.busy, 0);
    check("fault_done_low", bus.done, 0);
    check("fault_probe_zero", bus.probe, 0);
    check("fault_result_zero", bus.result, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("fault_no_done", bus.done, 0);
      check("fault_err_sticky", bus.err, 1);
    end
    run_search(4'd3, 1'b0);

    // Reset during the third compare.
    @(negedge clk);
    target = 4'd5;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_probe", bus.probe, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_done", bus.done, 0);
    check("midrst_result", bus.result, 0);
    check("midrst_err", bus.err, 0);
    @(negedge clk);
    rst = 1'b0;
    check("midrst_stays_idle", bus.busy, 0);
    run_search(4'd5, 1'b0);

    for (int n = 0; n < 16; n++) begin
      run_search(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/four_bit_sar_search.md
FOUR_BIT_SAR_SEARCH -- requirements
Module: four_bit_sar_search

Interface
REQ-001 SHALL have exactly one clock and an asynchronous active-high reset, fixed as decided.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 start  input  1  request a new search; sampled in IDLE only.
REQ-005 eq_in  input  1  external 4-bit magnitude comparator: target == probe.
REQ-006 gr_in  input  1  comparator: target > probe.
REQ-007 lt_in  input  1  comparator: target < probe.
REQ-008 probe  output  4  trial value driven to the comparator's second operand.
REQ-009 busy  output  1  high in SEARCH.
REQ-010 done  output  1  one-cycle pulse, result valid.
REQ-011 result  output  4  found target value; held until next accepted start.
REQ-012 err  output  1  comparator flags not one-hot during a compare; sticky until next accepted start.

Function
REQ-013 SHALL be the initiator for a magnitude comparator: find the unknown 4-bit target by successive approximation, MSB first.
REQ-014 States: IDLE, SEARCH, DONE.
REQ-015 IDLE: probe=0000, busy=0, done=0; start=1 at a clock edge -> SEARCH, bit index=3, probe=1000, err cleared, result cleared to 0000.
REQ-016 SEARCH: flags are combinational on probe and SHALL be sampled at each rising edge; one compare per cycle.
REQ-017 Compare rule at bit index i: gr_in=1 -> keep bit i; lt_in=1 -> clear bit i; eq_in=1 -> keep bit i (see REQ-026 for early exit).
REQ-018 If i>0, next probe = updated value with bit i-1 set; i decrements.
REQ-019 If i=0, result <= final value, state -> DONE.
REQ-020 DONE: done=1 for exactly one cycle, busy=0, probe=0000; unconditionally -> IDLE next edge.
REQ-021 Latency: start edge to done high = 5 cycles worst case (4 compares + DONE cycle).
REQ-022 Non-one-hot flags (none set, or >1 set) at a SEARCH edge -> err=1, result=0000, state -> IDLE without asserting done.
REQ-023 start while busy or in DONE SHALL be ignored; start held high in IDLE re-launches each time IDLE is reached.
REQ-024 Arithmetic: probe and result strictly 4-bit unsigned; no wrap, range 0..15 covered in 4 compares.

Reset
REQ-025 rst=1 at any time, including mid-search, SHALL immediately force IDLE, probe=0000, result=0000, busy=0, done=0, err=0, bit index=3; no compare sampled while rst=1.

Configuration
REQ-026 Macro SAR_EARLY_EXIT_EN: defined -> eq_in=1 at any SEARCH edge loads result=current probe and goes to DONE immediately (latency 2..5 cycles); undefined -> eq_in treated as gr_in, always exactly 4 compares (latency fixed at 5).

Verification
REQ-027 Bench models comparator with fixed target; target=9 -> probes 1000,1100,1010,1001; result=1001, done at cycle 5, err=0.
REQ-028 Target=8 -> with SAR_EARLY_EXIT_EN: probe 1000 only, done at cycle 2, result=1000; without: probes 1000,1100,1010,1001, result=1000, done at cycle 5.
REQ-029 Targets 0 and 15 -> probes 8,4,2,1 result 0000; probes 8,12,14,15 result 1111; no wrap.
REQ-030 Force gr_in=lt_in=1 on second compare -> err=1, no done pulse, back in IDLE; next start clears err.
REQ-031 Assert rst during third compare -> all outputs 0 same cycle; subsequent start for target=5 yields result=0101 normally.
REQ-032 start pulsed while busy -> ignored, original search completes with correct result.
